// File: rtl/div2.sv
// div2: 8-bit / 4-bit restoring shift-subtract divider, one quotient bit per clock.
// Optional divide-by-zero fast path and dz flag: define DIV2_ZERO_DETECT_EN.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | eight shift-subtract steps
//   FIN   | one-cycle done pulse, results valid
module div2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder
`ifdef DIV2_ZERO_DETECT_EN
  ,output logic      dz
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      state_q;
  logic [2:0]  step_q;
  logic [7:0]  sr_q;
  logic [3:0]  dvs_q;
  logic [3:0]  p_q;
  logic [7:0]  quotient_q;
  logic [3:0]  remainder_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  t_d;
  logic        ge_d;
  logic [3:0]  p_d;
  logic [7:0]  sr_d;
  logic        zd_hit;

`ifdef DIV2_ZERO_DETECT_EN
  logic        dz_q;
  assign zd_hit = (dvs_q == 4'd0);
  assign dz     = dz_q;
`else
  assign zd_hit = 1'b0;
`endif

  // A restored remainder is always below 16, so only the low four bits of P are stored
  // and the subtraction can be done modulo 16.
  always_comb begin
    t_d  = {p_q, sr_q[7]};
    ge_d = (t_d >= {1'b0, dvs_q});
    p_d  = t_d[3:0] - (ge_d ? dvs_q : 4'd0);
    sr_d = {sr_q[6:0], ge_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      sr_q        <= 8'h00;
      dvs_q       <= 4'h0;
      p_q         <= 4'h0;
      quotient_q  <= 8'h00;
      remainder_q <= 4'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV2_ZERO_DETECT_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (start) begin
            state_q <= S_RUN;
            sr_q    <= dividend;
            dvs_q   <= divisor;
            p_q     <= 4'h0;
            step_q  <= 3'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef DIV2_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (zd_hit) begin
            state_q     <= S_FIN;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= 8'hFF;
            remainder_q <= sr_q[3:0];
`ifdef DIV2_ZERO_DETECT_EN
            dz_q        <= 1'b1;
`endif
          end else begin
            sr_q   <= sr_d;
            p_q    <= p_d;
            step_q <= step_q + 3'd1;
            if (step_q == 3'd7) begin
              state_q     <= S_FIN;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= sr_d;
              remainder_q <= p_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div2.sv
// tb_div2: randomized and directed self-checking bench for div2 against an arithmetic model.
// Honours DIV2_ZERO_DETECT_EN the same way the design does.
module tb_div2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV2_ZERO_DETECT_EN
  logic       dz;
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_q  = 0;
  int unsigned exp_r  = 0;
  time         t_done = 0;

  div2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV2_ZERO_DETECT_EN
    ,.dz       (dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_div(input int unsigned a, input int unsigned b,
                                  output int unsigned q, output int unsigned r);
    if (b == 0) begin
      q = 255;
      r = a % 16;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issues one division and follows it cycle by cycle until the done pulse.
  // poke >= 0 re-asserts start with 100/3 after the poke-th busy cycle (must be ignored).
  task automatic run_div(input int unsigned a, input int unsigned b, input int poke);
    int          lat;
    int unsigned q, r;
    lat = (ZD && b == 0) ? 1 : 8;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 4'(b);
    @(posedge clk);
    #1;
    for (int k = 0; k <= lat; k++) begin
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      if (k < lat) begin
        check("busy_run", busy, 1);
        check("done_run", done, 0);
        check("q_hold", quotient, exp_q);
        check("r_hold", remainder, exp_r);
`ifdef DIV2_ZERO_DETECT_EN
        check("dz_run", dz, 0);
`endif
      end else begin
        ref_div(a, b, q, r);
        exp_q = q;
        exp_r = r;
        check("busy_fin", busy, 0);
        check("done_fin", done, 1);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
`ifdef DIV2_ZERO_DETECT_EN
        check("dz_fin", dz, (b == 0) ? 1 : 0);
`endif
        t_done = $time;
      end
      if (k == poke && k < lat) begin
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
      end
      if (k < lat) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic tail_idle();
    @(posedge clk);
    #1;
    check("done_fall", done, 0);
    check("busy_idle", busy, 0);
    check("q_idle", quotient, exp_q);
    check("r_idle", remainder, exp_r);
  endtask

  initial begin
    time t0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
`ifdef DIV2_ZERO_DETECT_EN
    check("rst_dz", dz, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_div(200, 7, -1);
    check("t200_7_q", quotient, 28);
    check("t200_7_r", remainder, 4);
    tail_idle();

    run_div(255, 15, -1);
    check("t255_15_q", quotient, 17);
    check("t255_15_r", remainder, 0);
    t0 = t_done;
    run_div(5, 9, -1);
    check("b2b_q", quotient, 0);
    check("b2b_r", remainder, 5);
    check("b2b_gap_ns", 32'(t_done - t0), 90);
    tail_idle();

    run_div(200, 7, 3);
    check("ignore_q", quotient, 28);
    check("ignore_r", remainder, 4);
    tail_idle();

    run_div(8'h3A, 0, -1);
    check("dz_q", quotient, 8'hFF);
    check("dz_r", remainder, 4'hA);
    tail_idle();

    // Reset in the middle of a division, then a fresh operation.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
`ifdef DIV2_ZERO_DETECT_EN
    check("arst_dz", dz, 0);
`endif
    exp_q = 0;
    exp_r = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_div(9, 2, -1);
    check("post_rst_q", quotient, 4);
    check("post_rst_r", remainder, 1);
    tail_idle();

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(a, b, -1);
        check("exh_identity", quotient * b + remainder, a);
        check("exh_r_lt_d", (remainder < b) ? 1 : 0, 1);
      end
    end
    tail_idle();

    for (int i = 0; i < 200; i++) begin
      int unsigned a, b;
      int          poke;
      a    = $urandom_range(0, 255);
      b    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
      run_div(a, b, poke);
      if ($urandom_range(0, 1) == 1) begin
        tail_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    tail_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
